wrpg_seq: RTL and testbench

Parametrised accumulator/LFSR test-pattern generator with a start/busy/done sequencer and valid/ready output handshake. It emits a programmed number of patterns from a seed, using one of four generation modes: accumulate, Galois LFSR, counter, or end-around-carry accumulate. It sits in front of the circuit under test and feeds it one pattern per accepted handshake.

---
 rtl/wrpg_seq.sv | 157 +++++++++++++++
 tb/tb_wrpg_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wrpg_seq.sv
// Test-pattern generator: accumulate / Galois LFSR / counter / end-around-carry modes.
// Optional output weighting is enabled with the WRPG_WEIGHT_EN macro.
module wrpg_seq #(
   parameter int              WIDTH = 8,
   parameter int              CNT_W = 16,
   parameter logic [WIDTH-1:0] POLY = WIDTH'('hB8)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] seed,
   input  logic [WIDTH-1:0] addend,
   input  logic             cin,
   input  logic [CNT_W-1:0] num_pat,
`ifdef WRPG_WEIGHT_EN
   input  logic [1:0]       weight,
`endif
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] pattern,
   output logic             cout,
   output logic [CNT_W-1:0] pat_idx,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] acc;
   logic             carry_reg;
   logic [1:0]       cfg_mode;
   logic [WIDTH-1:0] cfg_addend;
   logic             cfg_cin;
   logic [CNT_W-1:0] cfg_num;
   logic             load, adv;
   logic [WIDTH+1:0] step_res;

   // Returns {carry_reg_next, cout_next, acc_next} for one generation step.
   function automatic logic [WIDTH+1:0] step(input logic [1:0] m, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] ad, input logic ci,
                                             input logic cr);
      logic [WIDTH:0]   sum;
      logic [WIDTH-1:0] nxt;
      logic             co;
      logic             crn;
      sum = '0;
      nxt = a;
      co  = 1'b0;
      crn = cr;
      case (m)
         2'b00: begin
            sum = {1'b0, a} + {1'b0, ad} + {{WIDTH{1'b0}}, ci};
            nxt = sum[WIDTH-1:0];
            co  = sum[WIDTH];
         end
         2'b01: nxt = (a >> 1) ^ (a[0] ? POLY : '0);
         2'b10: begin
            sum = {1'b0, a} + (WIDTH+1)'(1);
            nxt = sum[WIDTH-1:0];
            co  = sum[WIDTH];
         end
         default: begin
            sum = {1'b0, a} + {1'b0, ad} + {{WIDTH{1'b0}}, cr};
            nxt = sum[WIDTH-1:0];
            co  = sum[WIDTH];
            crn = sum[WIDTH];
         end
      endcase
      return {crn, co, nxt};
   endfunction

   assign step_res = step(cfg_mode, acc, cfg_addend, cfg_cin, carry_reg);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      adv     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_n = (num_pat == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (ready) begin
               if (pat_idx == cfg_num - CNT_W'(1)) state_n = DONE;
               else                                adv     = 1'b1;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign valid = (state == RUN);
   assign busy  = (state == RUN);
   assign done  = (state == DONE);

   // Datapath: load on accepted start, advance on each non-final handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         carry_reg  <= 1'b0;
         cout       <= 1'b0;
         pat_idx    <= '0;
         cfg_mode   <= '0;
         cfg_addend <= '0;
         cfg_cin    <= 1'b0;
         cfg_num    <= '0;
      end else if (load) begin
         cfg_mode   <= mode;
         cfg_addend <= addend;
         cfg_cin    <= cin;
         cfg_num    <= num_pat;
         acc        <= (mode == 2'b01 && seed == '0) ? WIDTH'(1) : seed;
         carry_reg  <= cin;
         cout       <= 1'b0;
         pat_idx    <= '0;
      end else if (adv) begin
         {carry_reg, cout, acc} <= step_res;
         pat_idx                <= pat_idx + CNT_W'(1);
      end
   end

`ifdef WRPG_WEIGHT_EN
   logic [1:0]       cfg_weight;
   logic [WIDTH-1:0] rot;

   always_ff @(posedge clk) begin
      if (rst)       cfg_weight <= '0;
      else if (load) cfg_weight <= weight;
   end

   assign rot = {acc[0], acc[WIDTH-1:1]};

   always_comb begin
      pattern = acc;
      case (cfg_weight)
         2'd1:    pattern = acc & rot;
         2'd2:    pattern = acc | rot;
         2'd3:    pattern = ~acc;
         default: pattern = acc;
      endcase
   end
`else
   assign pattern = acc;
`endif

endmodule

// File: tb/tb_wrpg_seq.sv
// Self-checking bench for wrpg_seq: plan vectors, directed corner sequences, random runs vs model.
// Weight checks are included when WRPG_WEIGHT_EN is defined.
module tb_wrpg_seq;

   localparam int WIDTH = 8;
   localparam int CNT_W = 16;
   localparam int POLY  = 'hB8;

   logic             clk = 1'b0;
   logic             rst, start, cin, ready;
   logic [1:0]       mode;
   logic [WIDTH-1:0] seed, addend;
   logic [CNT_W-1:0] num_pat;
   logic [1:0]       weight;
   logic             valid, cout, busy, done;
   logic [WIDTH-1:0] pattern;
   logic [CNT_W-1:0] pat_idx;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_p [0:511];
   logic       exp_c [0:511];

   wrpg_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W), .POLY(8'hB8)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .addend(addend),
      .cin(cin), .num_pat(num_pat),
`ifdef WRPG_WEIGHT_EN
      .weight(weight),
`endif
      .ready(ready), .valid(valid), .pattern(pattern), .cout(cout), .pat_idx(pat_idx),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]      m;
      logic [7:0]      sd;
      logic [7:0]      ad;
      logic            c;
      logic [3:0]      n;
      logic [3:0][7:0] p;
      logic [3:0]      co;
   } vec_t;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   function automatic logic [7:0] weigh(input int p, input logic [1:0] w);
      int r;
      r = ((p >> 1) | ((p & 1) << 7)) & 255;
      case (w)
         2'd1:    return 8'(p & r);
         2'd2:    return 8'(p | r);
         2'd3:    return 8'(~p & 255);
         default: return 8'(p);
      endcase
   endfunction

   // Expected sequence from the mode rules using integer arithmetic.
   task automatic model_fill(input logic [1:0] m, input int sd, input int ad, input int c,
                             input int n, input logic [1:0] w);
      int p, cr, s, co;
      p  = (m == 2'b01 && sd == 0) ? 1 : sd;
      cr = c;
      co = 0;
      for (int k = 0; k < n; k++) begin
         if (k > 0) begin
            case (m)
               2'b00: begin s = p + ad + c; co = s / 256; p = s % 256; end
               2'b01: begin p = (p % 2 == 1) ? ((p / 2) ^ POLY) : (p / 2); co = 0; end
               2'b10: begin co = (p == 255) ? 1 : 0; p = (p + 1) % 256; end
               default: begin s = p + ad + cr; co = s / 256; cr = co; p = s % 256; end
            endcase
         end
         exp_p[k] = weigh(p, w);
         exp_c[k] = co[0];
      end
   endtask

   // Starts a run and follows it to completion, checking every cycle against exp_p/exp_c.
   task automatic run_seq(input logic [1:0] m, input logic [7:0] sd, input logic [7:0] ad,
                          input logic c, input int n, input bit rnd, input logic [1:0] w);
      int  k;
      bit  fin;
      logic rd;
      mode = m; seed = sd; addend = ad; cin = c; num_pat = CNT_W'(n); weight = w;
      start = 1'b1;
      tick;
      start = 1'b0;
      k = 0;
      fin = 1'b0;
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         if (done) fin = 1'b1;
         else begin
            chk("run_valid", valid, 1);
            chk("run_busy", busy, 1);
            chk("run_pattern", pattern, exp_p[k]);
            chk("run_cout", cout, exp_c[k]);
            chk("run_pat_idx", pat_idx, k);
            rd = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ready = rd;
            tick;
            if (rd) k++;
         end
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL run_timeout actual=no_done required=done");
      end
      chk("run_count", k, n);
      chk("done_valid", valid, 0);
      chk("done_busy", busy, 0);
      if (n > 0) begin
         chk("done_keep_pattern", pattern, exp_p[n-1]);
         chk("done_keep_idx", pat_idx, n - 1);
      end
      ready = 1'b0;
      tick;
      chk("done_one_cycle", done, 0);
      chk("idle_valid", valid, 0);
      if (n > 0) chk("idle_keep_pattern", pattern, exp_p[n-1]);
   endtask

   vec_t vecs [5];

   initial begin
      logic [7:0]  hold_p;
      logic [15:0] hold_i;
      logic [1:0]  m, w;
      int          n;

      vecs[0] = '{m:2'b00, sd:8'h00, ad:8'h25, c:1'b0, n:4'd4,
                  p:{8'h6F, 8'h4A, 8'h25, 8'h00}, co:4'b0000};
      vecs[1] = '{m:2'b00, sd:8'hF0, ad:8'h20, c:1'b1, n:4'd3,
                  p:{8'h00, 8'h32, 8'h11, 8'hF0}, co:4'b0010};
      vecs[2] = '{m:2'b11, sd:8'hF0, ad:8'h20, c:1'b1, n:4'd4,
                  p:{8'h52, 8'h32, 8'h11, 8'hF0}, co:4'b0010};
      vecs[3] = '{m:2'b01, sd:8'h00, ad:8'h00, c:1'b0, n:4'd4,
                  p:{8'h2E, 8'h5C, 8'hB8, 8'h01}, co:4'b0000};
      vecs[4] = '{m:2'b10, sd:8'hFE, ad:8'h00, c:1'b0, n:4'd3,
                  p:{8'h00, 8'h00, 8'hFF, 8'hFE}, co:4'b0100};

      rst = 1'b1; start = 1'b0; ready = 1'b0; mode = '0; seed = '0; addend = '0;
      cin = 1'b0; num_pat = '0; weight = '0;
      tick;
      tick;
      rst = 1'b0;
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pattern", pattern, 0);
      chk("rst_cout", cout, 0);
      chk("rst_pat_idx", pat_idx, 0);

      // Plan vectors with constant expectations, ready held high.
      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < 4; k++) begin
            exp_p[k] = vecs[i].p[k];
            exp_c[k] = vecs[i].co[k];
         end
         run_seq(vecs[i].m, vecs[i].sd, vecs[i].ad, vecs[i].c, int'(vecs[i].n), 1'b0, 2'd0);
      end

      // Zero-length run: done straight after start, never valid.
      run_seq(2'b00, 8'h12, 8'h01, 1'b0, 0, 1'b0, 2'd0);

      // Backpressure with an ignored start mid-run.
      mode = 2'b00; seed = 8'h10; addend = 8'h03; cin = 1'b0; num_pat = 16'd6;
      start = 1'b1; ready = 1'b1;
      tick;
      start = 1'b0;
      tick;
      tick;
      hold_p = pattern;
      hold_i = pat_idx;
      chk("bp_pre_pattern", pattern, 8'h16);
      chk("bp_pre_idx", pat_idx, 2);
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin start = 1'b1; seed = 8'hAA; mode = 2'b10; end
         tick;
         start = 1'b0;
         chk("bp_valid", valid, 1);
         chk("bp_pattern", pattern, hold_p);
         chk("bp_idx", pat_idx, hold_i);
      end
      ready = 1'b1;
      tick;
      chk("bp_resume_pattern", pattern, 8'h19);
      chk("bp_resume_idx", pat_idx, 3);

      // Reset in the middle of the run.
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("midrst_valid", valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_pattern", pattern, 0);
      chk("midrst_idx", pat_idx, 0);
      chk("midrst_cout", cout, 0);
      tick;
      chk("midrst_idle", valid, 0);
      ready = 1'b0;

      model_fill(2'b11, 8'hF0, 8'h20, 1, 4, 2'd0);
      run_seq(2'b11, 8'hF0, 8'h20, 1'b1, 4, 1'b1, 2'd0);

`ifdef WRPG_WEIGHT_EN
      exp_p[0] = 8'h00; exp_c[0] = 1'b0;
      exp_p[1] = 8'h18; exp_c[1] = 1'b0;
      run_seq(2'b01, 8'h00, 8'h00, 1'b0, 2, 1'b0, 2'd1);
      exp_p[0] = 8'hFE;
      exp_p[1] = 8'h47;
      run_seq(2'b01, 8'h00, 8'h00, 1'b0, 2, 1'b0, 2'd3);
`endif

      // Random runs against the model, random backpressure.
      for (int r = 0; r < 24; r++) begin
         m = 2'($urandom_range(0, 3));
         n = $urandom_range(0, 12);
`ifdef WRPG_WEIGHT_EN
         w = 2'($urandom_range(0, 3));
`else
         w = 2'd0;
`endif
         seed   = 8'($urandom_range(0, 255));
         addend = 8'($urandom_range(0, 255));
         cin    = 1'($urandom_range(0, 1));
         if (r % 6 == 0) seed = 8'h00;
         model_fill(m, int'(seed), int'(addend), int'(cin), n, w);
         run_seq(m, seed, addend, cin, n, 1'b1, w);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
